// File: rtl/od_pullup_tester.sv
// od_pullup_tester: open-drain pulse generator that times how fast each pad's
// external pull-up brings it back high and flags stuck-low / stuck-high pads.
module od_pullup_tester #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 21,
  parameter int RISE_W = 16,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'('h100000),
  parameter logic [CNT_W-1:0] DEF_LOW = CNT_W'('h80000)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CNT_W-1:0]           cfg_period,
  input  logic [CNT_W-1:0]           cfg_low,
  input  logic [CHANNELS-1:0]        ch_en,
  input  logic                       fault_clr,
  inout  tri   [CHANNELS-1:0]        pad,
  output logic [CHANNELS*RISE_W-1:0] rise_cycles,
  output logic [CHANNELS-1:0]        fault,
  output logic                       cycle_done
);
  typedef enum logic [1:0] {IDLE, LOW, RISE, HIGH} state_t;
  logic [CNT_W-1:0] cnt, period_s, low_s;
  logic [CHANNELS-1:0] en_s;
  logic wrap, at_low, in_low, rel;
  assign wrap = cnt == period_s;
  assign at_low = cnt == low_s;
  assign in_low = cnt <= low_s;
  // a low phase covering the whole period never releases the pad
  assign rel = at_low && low_s < period_s;
  assign cycle_done = wrap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      period_s <= DEF_PERIOD;
      low_s <= DEF_LOW;
      en_s <= '0;
    end else if (wrap) begin
      cnt <= '0;
      period_s <= cfg_period;
      low_s <= cfg_low;
      en_s <= ch_en;
    end else
      cnt <= cnt + 1'b1;
  for (genvar g = 0; g < CHANNELS; g++) begin : ch
    state_t state, state_nx;
    logic [1:0] sync;
    logic pin_s, hi_chk, start, done, tmo, f;
    logic [RISE_W-1:0] rc, rv;
    assign pad[g] = (en_s[g] && in_low) ? 1'b0 : 1'bz;
    assign pin_s = sync[1];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= '0;
      else sync <= {sync[0], pad[g]};
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
    always_comb
      state_nx = !en_s[g] ? IDLE :
                 state == IDLE ? (in_low ? LOW : IDLE) :
                 state == LOW  ? (rel ? RISE : LOW) :
                 state == RISE ? (pin_s ? HIGH : wrap ? LOW : RISE) :
                 (wrap ? LOW : HIGH);
    always_comb begin
      hi_chk = en_s[g] && state == LOW && at_low && pin_s;
      start = en_s[g] && state == LOW && rel;
      done = en_s[g] && state == RISE && pin_s;
      tmo = en_s[g] && state == RISE && !pin_s && wrap;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rc <= '0;
        rv <= '0;
        f <= 1'b0;
      end else begin
        rc <= start ? '0 : (state == RISE && !(&rc)) ? rc + 1'b1 : rc;
        rv <= done ? rc : tmo ? '1 : rv;
        f <= (hi_chk || tmo) ? 1'b1 : fault_clr ? 1'b0 : f;
      end
    assign fault[g] = f;
    assign rise_cycles[g*RISE_W +: RISE_W] = rv;
  end
endmodule

// File: tb/tb_od_pullup_tester.sv
// tb_od_pullup_tester: period-level reference model feeds a scoreboard queue;
// a monitor checks pads/cycle_done every cycle and pops results after each period.
module tb_od_pullup_tester;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] cfg_period = 5'd15;
  logic [4:0] cfg_low = 5'd7;
  logic [3:0] ch_en = 4'b0;
  logic fault_clr = 1'b0;
  tri [3:0] pad;
  logic [15:0] rise_cycles;
  logic [3:0] fault;
  logic cycle_done;

  logic [3:0] hold = 4'b0;
  logic [3:0] stk = 4'b0;
  int dly[4];
  int clr_at = -1;
  int chg_at = -1;
  logic [4:0] chg_low = 5'd7;
  logic [3:0] chg_en = 4'b0;
  logic [4:0] m_P = 5'd15;
  logic [4:0] m_L = 5'd7;
  logic [3:0] m_en = 4'b0;
  int er[4];
  logic [3:0] ef = 4'b0;
  logic [3:0] exp_pad = 4'hF;
  logic exp_done = 1'b0;
  logic pend = 1'b0;
  logic [19:0] exp_q[$];
  int total = 0;
  int bad = 0;

  od_pullup_tester #(.CHANNELS(4), .CNT_W(5), .RISE_W(4), .DEF_PERIOD(5'd15), .DEF_LOW(5'd7)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_period(cfg_period), .cfg_low(cfg_low), .ch_en(ch_en),
    .fault_clr(fault_clr), .pad(pad), .rise_cycles(rise_cycles), .fault(fault), .cycle_done(cycle_done)
  );

  // board model: pull-up on every pad, optional hold-low (slow/missing pull-up), optional short to VDD
  for (genvar g = 0; g < 4; g++) begin : board
    pullup pu (pad[g]);
    assign pad[g] = hold[g] ? 1'b0 : stk[g] ? 1'b1 : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic drive_cycle(input int k);
    int L, P;
    L = int'(m_L);
    P = int'(m_P);
    for (int i = 0; i < 4; i++) begin
      hold[i] = !stk[i] && m_en[i] && L < P && k > L && k <= L + dly[i];
      exp_pad[i] = !((m_en[i] && k <= L) || hold[i]);
    end
    exp_done = k == P;
  endtask

  task automatic run_period(input int stop);
    int L, P, s;
    logic set;
    L = int'(m_L);
    P = int'(m_P);
    if (stop < 0) begin
      for (int i = 0; i < 4; i++) begin
        set = 1'b0;
        s = 0;
        if (m_en[i]) begin
          if (stk[i] && L <= P) begin set = 1'b1; s = L; end
          if (L < P) begin
            if (stk[i]) er[i] = 0;
            else if (L + 3 + dly[i] < P) er[i] = dly[i] + 2;
            else begin er[i] = 15; set = 1'b1; s = P; end
          end
        end
        if (set && (clr_at < 0 || s >= clr_at)) ef[i] = 1'b1;
        else if (clr_at >= 0) ef[i] = 1'b0;
      end
      exp_q.push_back({4'(er[3]), 4'(er[2]), 4'(er[1]), 4'(er[0]), ef});
    end
    for (int k = 0; k <= P; k++) begin
      if (k > 0) @(negedge clk);
      if (k == stop) return;
      fault_clr = k == clr_at;
      if (k == chg_at) begin
        cfg_low = chg_low;
        ch_en = chg_en;
      end
      drive_cycle(k);
    end
    m_L = cfg_low;
    m_en = ch_en;
    m_P = cfg_period;
    @(negedge clk);
    fault_clr = 1'b0;
    drive_cycle(0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold = 4'b0;
    stk = 4'b0;
    fault_clr = 1'b0;
    exp_pad = 4'hF;
    exp_done = 1'b0;
    #1;
    chk("rst_fault", 20'(fault), 20'h0);
    chk("rst_rise", 20'(rise_cycles), 20'h0);
    chk("rst_pad", 20'(pad), 20'hF);
    chk("rst_done", 20'(cycle_done), 20'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_P = 5'd15;
    m_L = 5'd7;
    m_en = 4'b0;
    ef = 4'b0;
    for (int i = 0; i < 4; i++) er[i] = 0;
    drive_cycle(0);
  endtask

  task automatic plain();
    for (int i = 0; i < 4; i++) dly[i] = 0;
    stk = 4'b0;
    clr_at = -1;
    chg_at = -1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("cycle_done", 20'(cycle_done), 20'(exp_done));
      for (int i = 0; i < 4; i++)
        if (!stk[i]) chk($sformatf("pad%0d", i), 20'(pad[i]), 20'(exp_pad[i]));
      if (pend) begin
        if (exp_q.size() == 0) chk("sb_underflow", 20'h1, 20'h0);
        else chk("sb_result", {rise_cycles, fault}, exp_q.pop_front());
      end
      pend = cycle_done;
    end
  end

  initial begin
    int L, P;
    plain();
    @(negedge clk);
    do_reset();
    chg_at = 0; chg_low = 5'd7; chg_en = 4'b0001;
    run_period(-1);
    plain();
    run_period(-1);
    dly[0] = 3;
    run_period(-1);
    dly[0] = 31;
    run_period(-1);
    clr_at = 5;
    run_period(-1);
    plain(); clr_at = 2; chg_at = 0; chg_low = 5'd7; chg_en = 4'b0011;
    run_period(-1);
    plain(); stk = 4'b0010;
    run_period(-1);
    plain(); chg_at = 5; chg_low = 5'd3;
    run_period(-1);
    chg_low = 5'd15;
    run_period(-1);
    plain(); dly[0] = 31;
    run_period(-1);
    plain(); clr_at = 0; chg_at = 0; chg_low = 5'd7;
    run_period(-1);
    for (int n = 0; n < 40; n++) begin
      if (n == 20) begin
        plain();
        run_period(9);
        do_reset();
      end
      L = int'(m_L);
      P = int'(m_P);
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 5))
          5: dly[i] = 31;
          4: dly[i] = $urandom_range(0, 10);
          default: dly[i] = $urandom_range(0, 3);
        endcase
        if (L < P && L + 3 + dly[i] == P) dly[i]++;
      end
      stk = 4'b0;
      if ($urandom_range(0, 5) == 0 && (L + 1 < P || L >= P)) stk[$urandom_range(0, 3)] = 1'b1;
      clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      chg_at = $urandom_range(0, 15);
      chg_low = 5'($urandom_range(2, 15));
      chg_en = 4'($urandom_range(0, 15));
      run_period(-1);
    end
    #3;
    chk("sb_leftover", 20'(exp_q.size()), 20'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/od_pullup_tester.md
# od_pullup_tester

Multi-channel open-drain pulse generator and pull-up checker for board bring-up. Each enabled channel drives its pad low for a configurable portion of a shared period and releases it for the rest. After each release the block measures, in clock cycles, how long the external pull-up takes to return the pad high. It flags channels whose pad never rises (missing or weak pull-up) or never falls (pad shorted high). The block sits at the top level, directly on bidirectional IO pins.

## Interface

Parameters:
- `CHANNELS`, 4: number of open-drain pads.
- `CNT_W`, 21: period counter width.
- `RISE_W`, 16: rise-time result width per channel.
- `DEF_PERIOD`, 'h100000: reset value of the period shadow register.
- `DEF_LOW`, 'h80000: reset value of the low-time shadow register.

Ports:
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cfg_period`, input, CNT_W: counter terminal value. Period is `cfg_period+1` cycles.
- `cfg_low`, input, CNT_W: last counter value of the low phase.
- `ch_en`, input, CHANNELS: per-channel enable.
- `fault_clr`, input, 1: clears all fault bits.
- `pad`, inout, CHANNELS: open-drain pads. Each pad is driven to 0 or left at 'z, never driven to 1.
- `rise_cycles`, output, CHANNELS*RISE_W: last measured rise time. Channel i occupies bits [i*RISE_W +: RISE_W].
- `fault`, output, CHANNELS: sticky per-channel fault.
- `cycle_done`, output, 1: one-cycle pulse on the last cycle of each period.

## Operation

**Period counter and shadow registers**
- `cnt` counts 0..`period_s`, then wraps to 0.
- `period_s`, `low_s` and `en_s` are shadow copies of `cfg_period`, `cfg_low` and `ch_en`. They load only on the wrap edge, i.e. the clock edge in the cycle where `cnt==period_s`.
- Mid-period config changes have no effect until that wrap edge.
- Reset values: `period_s`=DEF_PERIOD, `low_s`=DEF_LOW, `en_s`=0.

**Pad drive**
- Pad i is driven low combinationally when `en_s[i] && cnt <= low_s`. Otherwise it is 'z.
- If `low_s >= period_s`, the pad stays low for the whole period. No release occurs, so no measurement and no rise-timeout fault.

**Readback**
- Each pad is read through a 2-flop synchronizer, producing `pin_s[i]`.
- The usable range requires `low_s >= 2` so that `pin_s` has settled before the stuck-high check.

**Per-channel FSM**

States are IDLE, LOW, RISE, HIGH.
- Any state → IDLE when `en_s[i]==0`.
- IDLE → LOW when enabled and `cnt <= low_s`.
- LOW:
  - If `cnt==low_s` and `pin_s==1`, set `fault[i]` (stuck-high).
  - Leave LOW for RISE on the edge of the cycle where `cnt==low_s`, clearing `rc` to 0.
- RISE, evaluated each cycle:
  - If `pin_s==1`: load `rise_cycles[i]` with `rc` and go to HIGH.
  - Else if `cnt==period_s`: set `fault[i]`, load `rise_cycles[i]` with all-ones, and go to LOW.
  - Else: increment `rc`, saturating at 2^RISE_W-1.
- HIGH → LOW on the wrap edge.

**Arithmetic**
- All comparisons are unsigned and CNT_W wide.
- `rc` is RISE_W wide and saturates rather than wrapping.

**Faults and cycle_done**
- `fault_clr` clears every `fault` bit on the next edge.
- If a fault set and `fault_clr` occur in the same cycle, the set wins.
- `cycle_done` is high exactly when `cnt==period_s`.

## Timing

- Reset values: `cnt`=0, all pads 'z (`en_s`=0), `fault`=0, `rise_cycles`=0, `cycle_done`=0 (because `period_s`≠0), all FSMs in IDLE, synchronizers at 0.
- Enable latency: `ch_en` takes effect at the first wrap edge after it is asserted. Pads begin driving low in the following cycle, where `cnt==0`.
- Release: the pad goes to 'z in the cycle where `cnt==low_s+1`.
- Measurement offset: an ideal pull-up reports `rise_cycles`=2, which is the synchronizer latency. True rise time equals the reported value minus 2.
- Result update: `rise_cycles[i]` updates on the edge that leaves RISE. It holds its value until the next measurement.
- Reset mid-operation: asynchronous. All pads release immediately and all state returns to the reset values listed above.

## Test plan

Bench parameters: DEF_PERIOD=15, DEF_LOW=7, RISE_W=4. Bench drives `cfg_period`=15, `cfg_low`=7. Pads modelled with weak pull-ups.

1. **Reset and enable timing.** Assert reset, then release; set `ch_en`=4'b0001. → All pads 'z until the first wrap. Then pad0 is low for `cnt` 0..7 and 'z for 8..15. `cycle_done` pulses every 16 cycles.
2. **Ideal pull-up.** Pull-up with zero delay. → `rise_cycles[0]`=2 after the first release; `fault`=0.
3. **Delayed rise.** Pad model delays the rise by 3 cycles after release. → `rise_cycles[0]`=5.
4. **Missing pull-up.** Pad0 pull-up removed. → `fault[0]`=1 at the cycle where `cnt`=15; `rise_cycles[0]`=4'hF. Then pulse `fault_clr` while pad0 still has no pull-up → `fault[0]` remains 1 because set wins over clear.
5. **Stuck-high pad.** Pad1 forced to 1 with `ch_en[1]`=1. → `fault[1]`=1 at `cnt`=7. Other channels unaffected.
6. **Mid-period config change.** Change `cfg_low` to 3 at `cnt`=5. → Current period still releases at `cnt`=8; the next period releases at `cnt`=4. Repeat with `cfg_low`=15 → no release, no fault.
